// File: rtl/mac_lane_sched.sv
// mac_lane_sched
// Sequencing controller for the eight-group MAC lane array. It latches one
// layer instruction as the lane configuration. It then gates the weight-load
// phase and the IFM issue phase. It also tracks the in-flight accumulations of
// each lane group until every group has returned its output_end. It handles
// handshakes only; no data passes through this block.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   i_inst_valid/o_inst_ready, i_inst   instruction handshake and payload
//                                        (packed mac_instruction_port)
//   o_lane_cfg          registered instruction driven to all lanes
//   i_wfm_valid/o_wfm_ready, i_wfm_is_last, o_wfm_load   weight phase
//   i_ifm_valid/o_ifm_ready, i_ifm_accum_end, i_ifm_last, o_ifm_issue
//                                        IFM phase
//   i_ofm_end           per-group output_end pulses from the lanes
//   o_busy, o_done      state != IDLE, one-cycle completion pulse
//   o_err               sticky: [0] count underflow, [1] drain timeout
//
// Optional build macro MAC_LANE_SCHED_PERF_EN adds the saturating performance
// counters o_perf_run_cyc, o_perf_stall_cyc and o_perf_drain_cyc.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for an instruction, o_inst_ready high
// WLOAD | accepting weight beats until the last one
// RUN   | issuing IFM beats, counting outstanding accumulations
// DRAIN | waiting for all groups to return output_end (timed)
// DONE  | one-cycle o_done pulse, then back to IDLE

module mac_lane_sched #(
    parameter int N_GROUP       = 8,
    parameter int MAX_OUTST     = 4,
    parameter int DRAIN_TIMEOUT = 1023,
    parameter int INST_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_inst_valid,
    output logic                 o_inst_ready,
    input  logic [INST_W-1:0]    i_inst,
    output logic [INST_W-1:0]    o_lane_cfg,
    input  logic                 i_wfm_valid,
    output logic                 o_wfm_ready,
    input  logic                 i_wfm_is_last,
    output logic                 o_wfm_load,
    input  logic                 i_ifm_valid,
    output logic                 o_ifm_ready,
    input  logic [N_GROUP-1:0]   i_ifm_accum_end,
    input  logic                 i_ifm_last,
    output logic [N_GROUP-1:0]   o_ifm_issue,
    input  logic [N_GROUP-1:0]   i_ofm_end,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [1:0]           o_err
`ifdef MAC_LANE_SCHED_PERF_EN
    ,
    output logic [31:0]          o_perf_run_cyc,
    output logic [31:0]          o_perf_stall_cyc,
    output logic [15:0]          o_perf_drain_cyc
`endif
);

    localparam int CNT_W = 4;
    localparam int TMR_W = 10;
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WLOAD = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                        state_q, state_d;
    logic                          rdy_en_q;
    logic [N_GROUP-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [TMR_W-1:0]              tmr_q, tmr_d;
    logic [1:0]                    err_d;
    logic [N_GROUP-1:0]            full, inc, dec, uflow;
    logic                          inst_acc, ifm_rdy, ifm_acc, all_zero, tmo, cnt_en;

    // Ready is withheld only for the reset cycles so that every handshake
    // output reads 0 while rst_n is low.
    assign inst_acc = (state_q == S_IDLE) & rdy_en_q & i_inst_valid;
    assign all_zero = (cnt_q == '0);
    assign cnt_en   = (state_q != S_IDLE);

    always_comb begin
        full = '0;
        for (int g = 0; g < N_GROUP; g++)
            full[g] = (cnt_q[g] == CNT_MAX);
    end

    // Stall only when a beat would push an already-full group over the limit.
    assign ifm_rdy     = (state_q == S_RUN) & ~(|(i_ifm_accum_end & full));
    assign ifm_acc     = ifm_rdy & i_ifm_valid;
    assign o_ifm_ready = ifm_rdy;
    assign o_ifm_issue = {N_GROUP{ifm_acc}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        o_inst_ready = 1'b0;
        o_wfm_ready  = 1'b0;
        o_wfm_load   = 1'b0;
        o_done       = 1'b0;
        o_busy       = 1'b1;
        tmo          = 1'b0;
        case (state_q)
            S_IDLE: begin
                o_busy       = 1'b0;
                o_inst_ready = rdy_en_q;
                if (inst_acc)
                    state_d = S_WLOAD;
            end
            S_WLOAD: begin
                o_wfm_ready = 1'b1;
                o_wfm_load  = i_wfm_valid;
                if (i_wfm_valid && i_wfm_is_last)
                    state_d = S_RUN;
            end
            S_RUN: begin
                if (ifm_acc && i_ifm_last)
                    state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (all_zero) begin
                    state_d = S_DONE;
                end else if (tmr_q == '0) begin
                    tmo     = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A dec against an empty counter is dropped and flagged.
    // Inc and dec together cancel out.
    always_comb begin
        inc   = '0;
        dec   = '0;
        uflow = '0;
        cnt_d = cnt_q;
        for (int g = 0; g < N_GROUP; g++) begin
            inc[g]   = ifm_acc & i_ifm_accum_end[g];
            dec[g]   = cnt_en & i_ofm_end[g];
            uflow[g] = dec[g] & ~inc[g] & (cnt_q[g] == '0);
            if (tmo)
                cnt_d[g] = '0;
            else if (inc[g] && !dec[g])
                cnt_d[g] = cnt_q[g] + CNT_W'(1);
            else if (dec[g] && !inc[g] && (cnt_q[g] != '0))
                cnt_d[g] = cnt_q[g] - CNT_W'(1);
        end
    end

    // Down-counter preloaded outside DRAIN. Terminal count 0 is reached in
    // the DRAIN_TIMEOUT-th DRAIN cycle.
    always_comb begin
        if (state_q != S_DRAIN)
            tmr_d = TMR_LOAD;
        else if (tmr_q != '0)
            tmr_d = tmr_q - TMR_W'(1);
        else
            tmr_d = tmr_q;
    end

    always_comb begin
        err_d = o_err;
        if (inst_acc) begin
            err_d = '0;
        end else begin
            if (|uflow)
                err_d[0] = 1'b1;
            if (tmo)
                err_d[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tmr_q      <= '0;
            o_err      <= '0;
            o_lane_cfg <= '0;
        end else begin
            cnt_q <= cnt_d;
            tmr_q <= tmr_d;
            o_err <= err_d;
            if (inst_acc)
                o_lane_cfg <= i_inst;
        end
    end

`ifdef MAC_LANE_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_perf_run_cyc   <= '0;
            o_perf_stall_cyc <= '0;
            o_perf_drain_cyc <= '0;
        end else if (inst_acc) begin
            o_perf_run_cyc   <= '0;
            o_perf_stall_cyc <= '0;
            o_perf_drain_cyc <= '0;
        end else begin
            if ((state_q == S_RUN) && !(&o_perf_run_cyc))
                o_perf_run_cyc <= o_perf_run_cyc + 32'd1;
            if ((state_q == S_RUN) && i_ifm_valid && !ifm_rdy && !(&o_perf_stall_cyc))
                o_perf_stall_cyc <= o_perf_stall_cyc + 32'd1;
            if ((state_q == S_DRAIN) && !(&o_perf_drain_cyc))
                o_perf_drain_cyc <= o_perf_drain_cyc + 16'd1;
        end
    end
`else
    // Performance counters are not built in this configuration.
`endif

endmodule
